// File: rtl/trap_ctrl.sv
// trap_ctrl: trap-entry / MRET sequencer for the machine-mode CSR file (EX stage).
//
// When a trap or MRET is taken, this block takes over the CSR file's single
// write port and issues the architectural updates one per cycle. It then pulses
// a fetch redirect. It also holds the current privilege mode.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   exc_valid/cause/pc/tval  trap request and its operands (cause[31] = interrupt)
//   mret_valid               MRET retiring
//   csr_req/addr/data        pipeline CSR-instruction write request
//   csr_gnt                  pipeline write accepted this cycle
//   mtvec_i/mstatus_i/mepc_i current CSR values read from the CSR file
//   csr_w_en/addr/data       CSR file write port
//   priv_mode                current privilege (11 M, 01 S, 00 U)
//   flush                    kill younger instructions (cycle a trap/MRET is taken)
//   busy                     a sequence is in progress; the pipeline stalls
//   redirect_valid/pc        one-cycle fetch redirect and its target
//
// Handshake: csr_req/csr_gnt is a valid/ready pair. A write transfers on any
// cycle where both are high. The requester holds csr_req, csr_req_addr and
// csr_req_data stable until that cycle. csr_gnt does not depend on csr_req
// being low or high beyond gating. It is high only in IDLE when no trap or
// MRET is being taken.
//
// The FSM state is in the signal 'state'. It can be probed hierarchically.

module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1,
  parameter bit MTVAL_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic        csr_req,
  input  logic [11:0] csr_req_addr,
  input  logic [31:0] csr_req_data,
  output logic        csr_gnt,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mepc_i,
  output logic        csr_w_en,
  output logic [11:0] csr_w_addr,
  output logic [31:0] csr_w_data,
  output logic [1:0]  priv_mode,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_JUMP, R_STATUS, R_JUMP
  } state_t;

  state_t      state;
  logic [29:0] epc_q;       // word-aligned PC; low two bits are always written as 0
  logic [31:0] cause_q;
  logic [31:0] tval_q;
  logic [1:0]  old_priv_q;  // privilege at trap entry, becomes MPP
  logic [1:0]  mpp_q;       // MPP captured during MRET, applied at the redirect

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      priv_mode  <= 2'b11;
      epc_q      <= '0;
      cause_q    <= '0;
      tval_q     <= '0;
      old_priv_q <= '0;
      mpp_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_valid) begin
            epc_q      <= exc_pc[31:2];
            cause_q    <= exc_cause;
            tval_q     <= exc_tval;
            old_priv_q <= priv_mode;
            // Enter M right away so the sequence's writes pass CSR-file gating.
            priv_mode  <= 2'b11;
            state      <= T_EPC;
          end else if (mret_valid) begin
            state <= R_STATUS;
          end
        end
        T_EPC:    state <= T_CAUSE;
        T_CAUSE:  state <= MTVAL_EN ? T_TVAL : T_STATUS;
        T_TVAL:   state <= T_STATUS;
        T_STATUS: state <= T_JUMP;
        T_JUMP:   state <= IDLE;
        R_STATUS: begin
          // Capture MPP here. priv_mode stays M until the redirect so the
          // MSTATUS write in this cycle is still accepted.
          mpp_q <= mstatus_i[12:11];
          state <= R_JUMP;
        end
        R_JUMP: begin
          priv_mode <= mpp_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= privilege before the trap.
  logic [31:0] trap_status;
  assign trap_status = {mstatus_i[31:13], old_priv_q, mstatus_i[10:8], mstatus_i[3],
                        mstatus_i[6:4], 1'b0, mstatus_i[2:0]};

  // MRET: MIE <= MPIE, MPIE <= 1, MPP <= U.
  logic [31:0] mret_status;
  assign mret_status = {mstatus_i[31:13], 2'b00, mstatus_i[10:8], 1'b1,
                        mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};

  // Vectored mode adds 4*cause to the base, for interrupts only. The shift
  // drops cause bit 31, so it cannot leak into the target address.
  logic [31:0] vec_offset;
  logic [31:0] trap_target;
  assign vec_offset  = (VECTORED_EN && (mtvec_i[1:0] == 2'b01) && cause_q[31])
                       ? {cause_q[29:0], 2'b00} : 32'd0;
  assign trap_target = {mtvec_i[31:2], 2'b00} + vec_offset;

  always_comb begin
    csr_gnt        = 1'b0;
    csr_w_en       = 1'b0;
    csr_w_addr     = '0;
    csr_w_data     = '0;
    flush          = 1'b0;
    busy           = (state != IDLE);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        flush = exc_valid | mret_valid;
        // A pipeline write gets the port only when no sequence is starting.
        // This keeps the write port single-sourced.
        if (!exc_valid && !mret_valid && csr_req) begin
          csr_gnt    = 1'b1;
          csr_w_en   = 1'b1;
          csr_w_addr = csr_req_addr;
          csr_w_data = csr_req_data;
        end
      end
      T_EPC: begin
        csr_w_en   = 1'b1;
        csr_w_addr = ADDR_MEPC;
        csr_w_data = {epc_q, 2'b00};
      end
      T_CAUSE: begin
        csr_w_en   = 1'b1;
        csr_w_addr = ADDR_MCAUSE;
        csr_w_data = cause_q;
      end
      T_TVAL: begin
        csr_w_en   = 1'b1;
        csr_w_addr = ADDR_MTVAL;
        csr_w_data = tval_q;
      end
      T_STATUS: begin
        csr_w_en   = 1'b1;
        csr_w_addr = ADDR_MSTATUS;
        csr_w_data = trap_status;
      end
      T_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = trap_target;
      end
      R_STATUS: begin
        csr_w_en   = 1'b1;
        csr_w_addr = ADDR_MSTATUS;
        csr_w_data = mret_status;
      end
      R_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized bench for trap_ctrl.
// Two instances share the same inputs. u_vec uses the default parameters.
// u_dir is built with VECTORED_EN=0, so every trap in u_dir lands on the
// direct base. Expected per-cycle outputs come from a transaction-level model.

module tb_trap_ctrl;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MTVAL   = 12'h343;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        exc_valid, mret_valid, csr_req;
  logic [31:0] exc_cause, exc_pc, exc_tval;
  logic [11:0] csr_req_addr;
  logic [31:0] csr_req_data, mtvec_i, mstatus_i, mepc_i;

  logic        a_gnt, a_w_en, a_flush, a_busy, a_rv;
  logic [11:0] a_addr;
  logic [31:0] a_data, a_rpc;
  logic [1:0]  a_priv;
  logic        b_gnt, b_w_en, b_flush, b_busy, b_rv;
  logic [11:0] b_addr;
  logic [31:0] b_data, b_rpc;
  logic [1:0]  b_priv;

  trap_ctrl u_vec (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid),
    .csr_req(csr_req), .csr_req_addr(csr_req_addr), .csr_req_data(csr_req_data),
    .csr_gnt(a_gnt), .mtvec_i(mtvec_i), .mstatus_i(mstatus_i), .mepc_i(mepc_i),
    .csr_w_en(a_w_en), .csr_w_addr(a_addr), .csr_w_data(a_data),
    .priv_mode(a_priv), .flush(a_flush), .busy(a_busy),
    .redirect_valid(a_rv), .redirect_pc(a_rpc)
  );

  trap_ctrl #(.VECTORED_EN(1'b0), .MTVAL_EN(1'b1)) u_dir (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid),
    .csr_req(csr_req), .csr_req_addr(csr_req_addr), .csr_req_data(csr_req_data),
    .csr_gnt(b_gnt), .mtvec_i(mtvec_i), .mstatus_i(mstatus_i), .mepc_i(mepc_i),
    .csr_w_en(b_w_en), .csr_w_addr(b_addr), .csr_w_data(b_data),
    .priv_mode(b_priv), .flush(b_flush), .busy(b_busy),
    .redirect_valid(b_rv), .redirect_pc(b_rpc)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        gnt;
    logic        w_en;
    logic [11:0] addr;
    logic [31:0] data;
    logic        flush;
    logic        busy;
    logic        rv;
    logic [31:0] rpc;
    logic [1:0]  priv;
  } cyc_t;

  cyc_t       exp_q[$];
  cyc_t       exp_dir_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [1:0] m_priv;

  function automatic cyc_t quiet(input logic [1:0] p);
    cyc_t c;
    c = '0;
    c.priv = p;
    return c;
  endfunction

  task automatic push2(input cyc_t c);
    exp_q.push_back(c);
    exp_dir_q.push_back(c);
  endtask

  // Write address/data and redirect target are don't-care when not asserted.
  task automatic check(input string tag, input cyc_t e, input cyc_t a);
    cyc_t em, am;
    em = e;
    am = a;
    if (!e.w_en) begin em.addr = '0; em.data = '0; am.addr = '0; am.data = '0; end
    if (!e.rv)   begin em.rpc = '0; am.rpc = '0; end
    tests++;
    assert (am === em) else begin
      fails++;
      $error("FAIL %s: got gnt=%b wen=%b addr=%h data=%h flush=%b busy=%b rv=%b rpc=%h priv=%b; expected gnt=%b wen=%b addr=%h data=%h flush=%b busy=%b rv=%b rpc=%h priv=%b",
             tag, am.gnt, am.w_en, am.addr, am.data, am.flush, am.busy, am.rv, am.rpc, am.priv,
             em.gnt, em.w_en, em.addr, em.data, em.flush, em.busy, em.rv, em.rpc, em.priv);
    end
  endtask

  // One clock: inputs already driven. Sample at negedge, then move past the
  // next rising edge.
  task automatic step(input string tag);
    cyc_t ea, eb, aa, ab;
    @(negedge clk);
    if (exp_q.size() == 0 || exp_dir_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: expected queue empty (got size %0d, required > 0)", tag, exp_q.size());
    end else begin
      ea = exp_q.pop_front();
      eb = exp_dir_q.pop_front();
      aa = {a_gnt, a_w_en, a_addr, a_data, a_flush, a_busy, a_rv, a_rpc, a_priv};
      ab = {b_gnt, b_w_en, b_addr, b_data, b_flush, b_busy, b_rv, b_rpc, b_priv};
      check({tag, "/vec"}, ea, aa);
      check({tag, "/dir"}, eb, ab);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_idle(input logic req, input logic keep);
    cyc_t c;
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    exc_cause  = $urandom;
    exc_pc     = $urandom;
    exc_tval   = $urandom;
    csr_req    = req;
    if (!keep) begin
      csr_req_addr = 12'($urandom);
      csr_req_data = $urandom;
    end
    c = quiet(m_priv);
    if (req) begin
      c.gnt  = 1'b1;
      c.w_en = 1'b1;
      c.addr = csr_req_addr;
      c.data = csr_req_data;
    end
    push2(c);
    step("idle");
  endtask

  // Trap: accept cycle, four CSR writes, one redirect cycle. abort_at >= 0
  // asserts rst during that cycle. hold forces a simultaneous MRET and a
  // held CSR request.
  task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input logic [31:0] mtvec,
                         input logic [31:0] mstatus, input int abort_at,
                         input logic hold);
    logic [1:0]  old;
    logic [31:0] base;
    cyc_t        c;
    old  = m_priv;
    base = mtvec & ~32'h3;
    c = quiet(old);
    c.flush = 1'b1;
    push2(c);
    c = quiet(2'b11);
    c.busy = 1'b1;
    c.w_en = 1'b1;
    c.addr = MEPC;    c.data = pc & ~32'h3; push2(c);
    c.addr = MCAUSE;  c.data = cause;       push2(c);
    c.addr = MTVAL;   c.data = tval;        push2(c);
    c.addr = MSTATUS;
    c.data = (mstatus & ~32'h1888) | (32'(mstatus[3]) << 7) | (32'(old) << 11);
    push2(c);
    c = quiet(2'b11);
    c.busy = 1'b1;
    c.rv   = 1'b1;
    c.rpc  = (mtvec[1:0] == 2'b01 && cause[31]) ? base + (cause << 2) : base;
    exp_q.push_back(c);
    c.rpc  = base;
    exp_dir_q.push_back(c);

    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        exc_valid  = 1'b1;
        exc_cause  = cause;
        exc_pc     = pc;
        exc_tval   = tval;
        mret_valid = hold ? 1'b1 : 1'($urandom);
      end else begin
        exc_valid  = 1'($urandom);
        mret_valid = 1'($urandom);
        exc_cause  = $urandom;
        exc_pc     = $urandom;
        exc_tval   = $urandom;
      end
      mtvec_i   = mtvec;
      mstatus_i = mstatus;
      mepc_i    = $urandom;
      if (hold) begin
        csr_req = 1'b1;
      end else begin
        csr_req      = 1'($urandom);
        csr_req_addr = 12'($urandom);
        csr_req_data = $urandom;
      end
      if (i == abort_at) rst = 1'b1;
      step("trap");
      if (i == abort_at) begin
        rst = 1'b0;
        exp_q.delete();
        exp_dir_q.delete();
        m_priv = 2'b11;
        return;
      end
    end
    m_priv = 2'b11;
  endtask

  task automatic do_mret(input logic [31:0] mstatus, input logic [31:0] mepc);
    cyc_t c;
    c = quiet(m_priv);
    c.flush = 1'b1;
    push2(c);
    c = quiet(m_priv);
    c.busy = 1'b1;
    c.w_en = 1'b1;
    c.addr = MSTATUS;
    c.data = (mstatus & ~32'h1888) | (32'(mstatus[7]) << 3) | 32'h80;
    push2(c);
    c = quiet(m_priv);
    c.busy = 1'b1;
    c.rv   = 1'b1;
    c.rpc  = mepc;
    push2(c);
    for (int i = 0; i < 3; i++) begin
      exc_valid    = (i == 0) ? 1'b0 : 1'($urandom);
      mret_valid   = (i == 0) ? 1'b1 : 1'($urandom);
      exc_cause    = $urandom;
      exc_pc       = $urandom;
      exc_tval     = $urandom;
      mtvec_i      = $urandom;
      mstatus_i    = mstatus;
      mepc_i       = mepc;
      csr_req      = 1'($urandom);
      csr_req_addr = 12'($urandom);
      csr_req_data = $urandom;
      step("mret");
    end
    m_priv = mstatus[12:11];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst          = 1'b1;
    exc_valid    = 1'b0;
    mret_valid   = 1'b0;
    csr_req      = 1'b0;
    exc_cause    = '0;
    exc_pc       = '0;
    exc_tval     = '0;
    csr_req_addr = '0;
    csr_req_data = '0;
    mtvec_i      = '0;
    mstatus_i    = '0;
    mepc_i       = '0;
    m_priv       = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and a same-cycle grant right after reset
    do_idle(1'b1, 1'b0);
    do_idle(1'b0, 1'b0);

    // MRET to U: MSTATUS 0x88, redirect 0x200, priv 00 afterwards
    do_mret(32'h0000_0080, 32'h0000_0200);
    do_idle(1'b0, 1'b0);

    // Exception from U
    do_trap(32'd2, 32'h0000_0104, 32'hDEAD_BEEF, 32'h8000_0000, 32'h0000_0008, -1, 1'b0);
    do_idle(1'b0, 1'b0);

    // Vectored interrupt (u_dir expects the direct base)
    do_trap(32'h8000_0007, $urandom, $urandom, 32'h8000_0001, $urandom, -1, 1'b0);

    // Simultaneous exc/mret/csr_req; held request granted afterwards
    csr_req_addr = 12'h7C0;
    csr_req_data = 32'h1234_5678;
    do_trap($urandom, $urandom, $urandom, $urandom, $urandom, -1, 1'b1);
    do_idle(1'b1, 1'b1);

    // Reset during T_CAUSE
    do_mret(32'h0000_0000, 32'h0000_0300);
    do_trap(32'd5, 32'h0000_0400, 32'h0000_0055, 32'h0000_1000, 32'h0000_0008, 2, 1'b0);
    do_idle(1'b0, 1'b0);
    do_idle(1'b0, 1'b0);
    do_idle(1'b1, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: do_idle(1'b0, 1'b0);
        1: do_idle(1'b1, 1'b0);
        2: do_trap($urandom, $urandom, $urandom, $urandom, $urandom, -1, 1'b0);
        default: do_mret($urandom, $urandom);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap and return sequencer for the machine-mode CSR file in the EX stage.
- On an exception/interrupt or MRET it owns the CSR file's single write port and issues the architectural CSR updates over several cycles, then redirects fetch.
- Holds the current privilege mode that feeds the CSR file's write gating.
- Arbitrates the write port between its own sequence and ordinary CSR-instruction writes from the pipeline.

Parameters:
- VECTORED_EN, 1: 1 = honour mtvec.MODE==1 (vectored) for interrupts; 0 = always direct.
- MTVAL_EN, 1: 1 = sequence writes MTVAL; 0 = T_TVAL state skipped.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- exc_valid  in  1  trap request from pipeline (exception or interrupt)
- exc_cause  in  32  mcause value; bit31 = interrupt
- exc_pc  in  32  PC of trapping instruction
- exc_tval  in  32  trap value
- mret_valid  in  1  MRET retiring
- csr_req  in  1  pipeline CSR-instruction write request
- csr_req_addr  in  12  its CSR address
- csr_req_data  in  32  its write data
- csr_gnt  out  1  pipeline write accepted this cycle
- mtvec_i  in  32  current mtvec from CSR file
- mstatus_i  in  32  current mstatus
- mepc_i  in  32  current mepc
- csr_w_en  out  1  to CSR file w_en
- csr_w_addr  out  12  to CSR file w_addr
- csr_w_data  out  32  to CSR file w_data
- priv_mode  out  2  current privilege (11 M, 01 S, 00 U)
- flush  out  1  kill younger instructions
- busy  out  1  sequence in progress; pipeline stalls
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (rst=1 at edge): state IDLE, priv_mode=2'b11, capture registers 0. Combinational outputs then evaluate to 0 in IDLE with no requests. rst mid-sequence abandons it immediately; no partial redirect.
- States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_JUMP, R_STATUS, R_JUMP.
- IDLE priority: exc_valid > mret_valid > csr_req.
- exc_valid in IDLE (cycle 0):
  - flush=1 combinationally.
  - Latch exc_cause/pc/tval and old priv_mode.
  - priv_mode<=11 at that edge, so trap writes pass CSR-file gating.
  - Next state T_EPC.
- Trap write cycles (csr_w_en=1):
  - T_EPC: addr MEPC, data {pc[31:2],2'b00}.
  - T_CAUSE: addr MCAUSE, data latched cause.
  - T_TVAL: addr MTVAL, data latched tval.
  - T_STATUS: addr MSTATUS, data mstatus_i with bit7(MPIE)=mstatus_i[3], bit3(MIE)=0, bits12:11(MPP)=latched old priv.
- T_JUMP: redirect_valid=1, csr_w_en=0.
  - redirect_pc = {mtvec_i[31:2],2'b00} + (VECTORED_EN && mtvec_i[1:0]==01 && cause[31] ? cause[30:0]<<2 : 0), 32-bit wrap.
  - Next state IDLE.
- Trap latency: accept cycle 0, writes cycles 1–4 (1–3 if MTVAL_EN=0), redirect cycle 5 (4), IDLE cycle 6 (5).
- mret_valid in IDLE, no exc_valid:
  - flush=1; next state R_STATUS.
  - R_STATUS: write MSTATUS = mstatus_i with MIE=mstatus_i[7], MPIE=1, MPP=00; latch MPP=mstatus_i[12:11].
  - R_JUMP: redirect_valid=1, redirect_pc=mepc_i; priv_mode<=latched MPP at end of R_JUMP; next state IDLE.
  - priv_mode stays 11 through R_STATUS so its write is accepted.
- busy=1 in every state except IDLE.
- exc_valid/mret_valid while busy are ignored. Pipeline is flushed/stalled, so this cannot occur legally; the bench checks it is ignored.
- csr_req arbitration:
  - csr_gnt=1 only in IDLE with exc_valid=0 and mret_valid=0.
  - Then csr_w_en=1, addr/data pass through combinationally, zero latency.
  - Otherwise csr_gnt=0; requester holds csr_req and operands stable until granted.
  - Privilege checking remains in the CSR file.
- csr_w_en is never asserted for two sources in one cycle.

Test Plan:
- Reset: rst=1 two cycles → priv_mode=11, busy=0, csr_w_en=0, redirect_valid=0; csr_req in the first post-reset cycle gets csr_gnt=1 the same cycle.
- Exception from U: priv=00 via prior MRET; exc_cause=2, exc_pc=0x104, exc_tval=0xDEADBEEF, mtvec_i=0x80000000, mstatus_i=0x8 →
  - writes in order: MEPC=0x104, MCAUSE=2, MTVAL=0xDEADBEEF, MSTATUS=0x80.
  - redirect_pc=0x80000000 on cycle 5; priv_mode=11.
- Vectored interrupt: mtvec_i=0x80000001, exc_cause=0x80000007 → redirect_pc=0x8000001C; with VECTORED_EN=0 → 0x80000000.
- MRET: mstatus_i=0x80 (MPIE=1, MPP=00), mepc_i=0x200 → MSTATUS write 0x88 cycle 1, redirect 0x200 cycle 2, priv_mode=00 from cycle 3.
- Simultaneous exc_valid, mret_valid, csr_req in IDLE → trap sequence runs, csr_gnt=0 for 6 cycles; held csr_req granted in IDLE cycle 6.
- rst asserted during T_CAUSE → next cycle IDLE, priv_mode=11, no MTVAL/MSTATUS write, no redirect_valid.
